// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_pkg
// Purpose  : Shared types and constants for the 4-input mux round-robin arbiter
// Revision : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    typedef logic [NUM_REQ-1:0] req_vec_t;

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_pick
// Purpose  : Combinational rotating-priority pick: first set request at or after i_ptr
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [SEL_W-1:0]   i_ptr,
    output logic               o_found,
    output logic [SEL_W-1:0]   o_idx
);

    logic [SEL_W-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = i_ptr;
        w_cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = i_ptr + SEL_W'(k);
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter
// Purpose  : Round-robin burst arbiter driving the select/enable of a 4:1 mux
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] last_i,
    input  logic               out_ready_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [SEL_W-1:0]   sel_o,
    output logic               enb_o,
    output logic               out_valid_o,
    output logic               busy_o
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [0:0]       c_ST_IDLE   = IDLE;
    localparam logic [0:0]       c_ST_GRANT  = GRANT;
    localparam logic [CNT_W-1:0] c_LAST_BEAT = CNT_W'(MAX_BURST - 1);

    logic [0:0]         r_state;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   r_sel;
    logic [NUM_REQ-1:0] r_gnt;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_granted;
    logic               w_cur_req;
    logic               w_xfer;
    logic               w_release;
    logic [SEL_W-1:0]   w_pick_ptr;
    logic               w_found;
    logic [SEL_W-1:0]   w_idx;

    assign w_granted = (r_state == c_ST_GRANT);
    assign w_cur_req = req_i[r_sel];
    assign w_xfer    = w_granted & w_cur_req & out_ready_i;
    assign w_release = w_granted &
                       (~w_cur_req | (w_xfer & (last_i[r_sel] | (r_cnt == c_LAST_BEAT))));

    // While granted, search from the slot after the owner so it ends up lowest priority.
    assign w_pick_ptr = w_granted ? (r_sel + SEL_W'(1)) : r_ptr;

    rr_priority_pick u_pick (
        .i_req   (req_i),
        .i_ptr   (w_pick_ptr),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_gnt   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_found) begin
                        r_state <= c_ST_GRANT;
                        r_sel   <= w_idx;
                        r_gnt   <= req_vec_t'(1) << w_idx;
                        r_cnt   <= '0;
                    end
                end
                c_ST_GRANT: begin
                    if (w_release) begin
                        r_ptr <= w_pick_ptr;
                        r_cnt <= '0;
                        if (w_found) begin
                            r_sel <= w_idx;
                            r_gnt <= req_vec_t'(1) << w_idx;
                        end else begin
                            r_state <= c_ST_IDLE;
                            r_gnt   <= '0;
                        end
                    end else if (w_xfer) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign gnt_o       = r_gnt;
    assign sel_o       = r_sel;
    assign enb_o       = w_xfer;
    assign out_valid_o = w_granted & w_cur_req;
    assign busy_o      = w_granted;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_arbiter
// Purpose  : Self-checking bench for mux_rr_arbiter (MAX_BURST=4 and MAX_BURST=1)
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;
    import mux_arb_pkg::*;

    localparam int c_NDUT = 2;

    logic     clk = 1'b0;
    logic     rst;
    req_vec_t req;
    req_vec_t last;
    logic     rdy;

    req_vec_t         gnt   [c_NDUT];
    logic [SEL_W-1:0] sel   [c_NDUT];
    logic             enb   [c_NDUT];
    logic             valid [c_NDUT];
    logic             busy  [c_NDUT];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.MAX_BURST(4)) u_dut_mb4 (
        .clk(clk), .rst(rst), .req_i(req), .last_i(last), .out_ready_i(rdy),
        .gnt_o(gnt[0]), .sel_o(sel[0]), .enb_o(enb[0]),
        .out_valid_o(valid[0]), .busy_o(busy[0])
    );

    mux_rr_arbiter #(.MAX_BURST(1)) u_dut_mb1 (
        .clk(clk), .rst(rst), .req_i(req), .last_i(last), .out_ready_i(rdy),
        .gnt_o(gnt[1]), .sel_o(sel[1]), .enb_o(enb[1]),
        .out_valid_o(valid[1]), .busy_o(busy[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner index (-1 = nobody), pointer, beats done in this grant.
    int m_g   [c_NDUT];
    int m_ptr [c_NDUT];
    int m_cnt [c_NDUT];
    int m_sel [c_NDUT];

    logic seen_enb   [c_NDUT];
    logic seen_valid [c_NDUT];
    int   sel_log [$];

    function automatic int max_burst(int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int scan(req_vec_t r, int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(logic r, req_vec_t rq, req_vec_t ls, logic rd);
        int  w;
        logic xfer, rel, ev;
        rst  = r;
        req  = rq;
        last = ls;
        rdy  = rd;
        #2;
        for (int d = 0; d < c_NDUT; d++) begin
            ev = (m_g[d] >= 0) && rq[m_g[d]];
            check($sformatf("valid%0d", d), 32'(valid[d]), 32'(ev));
            check($sformatf("enb%0d", d), 32'(enb[d]), 32'(ev && rd));
            seen_enb[d]   = enb[d];
            seen_valid[d] = valid[d];
        end
        if (enb[0]) sel_log.push_back(int'(sel[0]));
        @(posedge clk);
        for (int d = 0; d < c_NDUT; d++) begin
            if (r) begin
                m_g[d] = -1; m_ptr[d] = 0; m_cnt[d] = 0; m_sel[d] = 0;
            end else if (m_g[d] < 0) begin
                w = scan(rq, m_ptr[d]);
                if (w >= 0) begin
                    m_g[d] = w; m_sel[d] = w; m_cnt[d] = 0;
                end
            end else begin
                xfer = rq[m_g[d]] && rd;
                rel  = !rq[m_g[d]] || (xfer && (ls[m_g[d]] || m_cnt[d] == max_burst(d) - 1));
                if (rel) begin
                    m_ptr[d] = (m_g[d] + 1) % NUM_REQ;
                    m_cnt[d] = 0;
                    w = scan(rq, m_ptr[d]);
                    m_g[d] = w;
                    if (w >= 0) m_sel[d] = w;
                end else if (xfer) begin
                    m_cnt[d]++;
                end
            end
        end
        #1;
        for (int d = 0; d < c_NDUT; d++) begin
            check($sformatf("gnt%0d", d), 32'(gnt[d]),
                  (m_g[d] < 0) ? 32'd0 : (32'd1 << m_g[d]));
            check($sformatf("busy%0d", d), 32'(busy[d]), 32'(m_g[d] >= 0));
            check($sformatf("sel%0d", d), 32'(sel[d]), 32'(m_sel[d]));
        end
    endtask

    task automatic do_reset();
        step(1'b1, 4'b0000, 4'b0000, 1'b1);
    endtask

    initial begin
        for (int d = 0; d < c_NDUT; d++) begin
            m_g[d] = -1; m_ptr[d] = 0; m_cnt[d] = 0; m_sel[d] = 0;
        end
        rst = 1'b1; req = '0; last = '0; rdy = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        do_reset();
        check("reset_gnt", 32'(gnt[0]), 32'd0);
        check("reset_busy", 32'(busy[0]), 32'd0);
        check("reset_sel", 32'(sel[0]), 32'd0);

        // Reset mid-burst, then a fresh grant must allow a full 4-beat burst.
        step(1'b0, 4'b0001, 4'b0000, 1'b1);
        step(1'b0, 4'b0001, 4'b0000, 1'b1);
        step(1'b0, 4'b0001, 4'b0000, 1'b1);
        step(1'b1, 4'b0001, 4'b0000, 1'b1);
        check("rst_mid_gnt", 32'(gnt[0]), 32'd0);
        check("rst_mid_busy", 32'(busy[0]), 32'd0);
        step(1'b0, 4'b0011, 4'b0000, 1'b1);
        check("regrant0", 32'(gnt[0]), 32'b0001);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0011, 4'b0000, 1'b1);
        check("regrant0_hold", 32'(gnt[0]), 32'b0001);
        step(1'b0, 4'b0011, 4'b0000, 1'b1);
        check("regrant0_rel", 32'(gnt[0]), 32'b0010);

        // Single requester: 1-cycle grant latency, back-to-back regrant.
        do_reset();
        step(1'b0, 4'b0100, 4'b0000, 1'b1);
        check("single_gnt", 32'(gnt[0]), 32'b0100);
        check("single_sel", 32'(sel[0]), 32'd2);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b0100, 4'b0000, 1'b1);
            check("single_nobubble", 32'(seen_enb[0]), 32'd1);
        end

        // Fairness with every requester asserting last.
        do_reset();
        sel_log.delete();
        for (int i = 0; i < 6; i++) step(1'b0, 4'b1111, 4'b1111, 1'b1);
        check("fair_count", 32'(sel_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < sel_log.size(); i++)
            check($sformatf("fair_order%0d", i), 32'(sel_log[i]), 32'(i % 4));

        // Back-pressure freezes the counter: 1 + 3 beats still hold, 4th releases.
        do_reset();
        step(1'b0, 4'b0010, 4'b0000, 1'b1);
        step(1'b0, 4'b0011, 4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b0011, 4'b0000, 1'b0);
            check("bp_enb", 32'(seen_enb[0]), 32'd0);
            check("bp_valid", 32'(seen_valid[0]), 32'd1);
            check("bp_gnt", 32'(gnt[0]), 32'b0010);
        end
        for (int i = 0; i < 2; i++) step(1'b0, 4'b0011, 4'b0000, 1'b1);
        check("bp_resume_hold", 32'(gnt[0]), 32'b0010);
        step(1'b0, 4'b0011, 4'b0000, 1'b1);
        check("bp_release", 32'(gnt[0]), 32'b0001);

        // Withdraw by requester 3: pointer wraps to 0.
        do_reset();
        step(1'b0, 4'b1000, 4'b0000, 1'b1);
        check("wd_gnt3", 32'(gnt[0]), 32'b1000);
        step(1'b0, 4'b1000, 4'b0000, 1'b1);
        step(1'b0, 4'b0001, 4'b1000, 1'b1);
        check("wd_no_xfer", 32'(seen_enb[0]), 32'd0);
        check("wd_sel", 32'(sel[0]), 32'd0);
        check("wd_gnt0", 32'(gnt[0]), 32'b0001);

        // last_i cuts the burst after two beats; 1 wins over 2.
        do_reset();
        step(1'b0, 4'b0100, 4'b0000, 1'b1);
        step(1'b0, 4'b0110, 4'b0000, 1'b1);
        check("last_hold", 32'(gnt[0]), 32'b0100);
        step(1'b0, 4'b0110, 4'b0100, 1'b1);
        check("last_next", 32'(gnt[0]), 32'b0010);

        // Randomized traffic checked against the model on both instances.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            req_vec_t rq;
            req_vec_t ls;
            for (int b = 0; b < NUM_REQ; b++) begin
                rq[b] = ($urandom_range(99) < 65);
                ls[b] = ($urandom_range(99) < 25);
            end
            step($urandom_range(199) == 0, rq, ls, $urandom_range(99) < 80);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
